ifu_fetch: RTL
==============

# ifu_fetch

Instruction fetch stage of the multicycle NPC core, directly upstream of the decode stage. It owns the architectural PC and fetches one 32-bit instruction per cycle of the pipeline loop over an AXI4-Lite read channel (AR/R only). It presents `{pc, inst}` to decode with a valid/ready handshake, then waits for decode's next-PC verdict before issuing the next fetch. Verdict: branch target or PC+4.

## Interface
- `RESET_PC`, default 32'h8000_0000, PC loaded on reset.
- `clock`  in  1  sole clock; all state updates on posedge.
- `reset`  in  1  asynchronous, active-high reset.
- `valid_post_o`  out  1  `pc_o`/`inst_o` hold a fetched instruction for decode.
- `ready_post_i`  in  1  decode accepts the instruction this cycle.
- `pc_o`  out  32  PC of the presented instruction.
- `inst_o`  out  32  fetched instruction word.
- `npc_valid_i`  in  1  decode's next-PC verdict is valid this cycle.
- `branch_en_i`  in  1  with `npc_valid_i`: 1 = redirect to `dnpc_i`, 0 = sequential.
- `dnpc_i`  in  32  redirect target.
- `araddr_o`  out  32  AXI read address; equals PC.
- `arvalid_o`  out  1  AXI read address valid.
- `arready_i`  in  1  AXI read address ready.
- `rdata_i`  in  32  AXI read data.
- `rresp_i`  in  2  AXI read response.
- `rvalid_i`  in  1  AXI read data valid.
- `rready_o`  out  1  AXI read data ready.
- `fault_o`  out  1  sticky fetch fault. Exists only with `IFU_FAULT_EN`.

## Operation
- States: IDLE, ADDR, DATA, HOLD, WAIT_NPC.
- IDLE: entered only via reset. Unconditionally goes to ADDR on the next clock.
- ADDR:
  - Drives `arvalid_o`=1, `araddr_o`=pc.
  - On `arready_i`, goes to DATA.
  - `araddr_o` and `arvalid_o` must not change while waiting.
- DATA:
  - Drives `rready_o`=1.
  - On `rvalid_i`, latches `rdata_i` into the inst register and goes to HOLD.
  - `rresp_i` is ignored unless `IFU_FAULT_EN` is defined.
- HOLD:
  - Drives `valid_post_o`=1. `pc_o`/`inst_o` are stable until the handshake.
  - On `ready_post_i`, goes to WAIT_NPC.
  - If `npc_valid_i` is also high in that same cycle, the PC updates and the FSM goes directly to ADDR.
- WAIT_NPC:
  - On `npc_valid_i`, pc ← `branch_en_i` ? `dnpc_i` : pc+4, then goes to ADDR.
- pc+4 wraps modulo 2^32. `dnpc_i` is taken as-is; no alignment masking.
- `npc_valid_i` in IDLE, ADDR or DATA is ignored, as is `npc_valid_i` in HOLD without `ready_post_i`. PC is unchanged in all these cases.
- Exactly one AR and one R transfer per instruction; no outstanding requests beyond one.

## Timing
- Reset values:
  - state=IDLE, pc=`RESET_PC`, inst=32'h0000_0013 (nop).
  - `arvalid_o`=0, `rready_o`=0, `valid_post_o`=0, `fault_o`=0.
- Outputs `arvalid_o`, `rready_o` and `valid_post_o` are decoded from registered state only. No combinational path from any input.
- Best-case fetch, with `arready_i` high in ADDR and `rvalid_i` high on the first DATA cycle:
  - ADDR at cycle n, DATA at n+1, `valid_post_o` at n+2.
- Reset release: the first `arvalid_o` is seen one cycle after IDLE, i.e. the second posedge after deassertion.
- Reset mid-transaction: the FSM returns to IDLE immediately.
  - The outstanding AXI transfer is abandoned; the slave is reset by the same signal.
  - A late `rvalid_i` arriving in IDLE or ADDR is not accepted, since `rready_o`=0.

## Configuration
- `IFU_FAULT_EN` defined:
  - In DATA, `rvalid_i` with `rresp_i`≠0 sets `fault_o`=1 (sticky until reset) and the FSM parks in IDLE without advancing.
  - `npc_valid_i` with `branch_en_i`=1 and `dnpc_i[1:0]`≠0 does the same.
- `IFU_FAULT_EN` undefined:
  - The `fault_o` port is absent.
  - Responses are always accepted as data, and misaligned targets are fetched unmodified.

## Test plan
- Reset release, `arready_i`=1, `rvalid_i`=1 with rdata 32'h0010_0093:
  - `araddr_o`=32'h8000_0000 on the 2nd posedge after release.
  - `valid_post_o`=1 two cycles later, `pc_o`=32'h8000_0000, `inst_o`=32'h0010_0093.
- Hold `ready_post_i`=0 for 5 cycles in HOLD: `pc_o`/`inst_o` stable and no new `arvalid_o`. Raise ready, then `npc_valid_i`=1 with `branch_en_i`=0: next `araddr_o`=32'h8000_0004.
- In WAIT_NPC, `npc_valid_i`=1, `branch_en_i`=1, `dnpc_i`=32'h8000_0100: next `araddr_o`=32'h8000_0100.
- `arready_i` delayed 3 cycles and `rvalid_i` delayed 4: `araddr_o` constant throughout, exactly one R beat accepted, correct inst presented.
- pc=32'hFFFF_FFFC with sequential verdict: next `araddr_o`=32'h0000_0000.
- Reset asserted in DATA, then `rvalid_i` pulsed after release during IDLE: pulse ignored, refetch from 32'h8000_0000. With `IFU_FAULT_EN`, `rresp_i`=2'b10: `fault_o`=1 and no further `arvalid_o`.

Source files
------------

// File: rtl/ifu_fetch.sv
`default_nettype none
// ============================================================================
// Module   : ifu_fetch
// Brief    : Instruction fetch stage; owns the PC, fetches one word per loop
//            over AXI4-Lite AR/R, hands {pc, inst} to decode, awaits next-PC.
//            Optional sticky fault detection under `IFU_FAULT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic        valid_post_o,
    input  logic        ready_post_i,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    input  logic        npc_valid_i,
    input  logic        branch_en_i,
    input  logic [31:0] dnpc_i,
    output logic [31:0] araddr_o,
    output logic        arvalid_o,
    input  logic        arready_i,
    input  logic [31:0] rdata_i,
    input  logic [1:0]  rresp_i,
    input  logic        rvalid_i,
    output logic        rready_o
`ifdef IFU_FAULT_EN
    ,
    output logic        fault_o
`endif
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ADDR     = 3'd1,
        S_DATA     = 3'd2,
        S_HOLD     = 3'd3,
        S_WAIT_NPC = 3'd4
    } state_t;

    localparam logic [31:0] C_NOP = 32'h0000_0013;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic        w_npc_take;
    logic [31:0] w_npc;

    // A verdict is only honoured once decode has taken the instruction.
    assign w_npc_take = ((r_state == S_HOLD) && ready_post_i && npc_valid_i) ||
                        ((r_state == S_WAIT_NPC) && npc_valid_i);
    assign w_npc      = branch_en_i ? dnpc_i : (r_pc + 32'd4);

`ifdef IFU_FAULT_EN
    logic r_fault;
    logic w_bad_resp;
    logic w_bad_target;

    assign w_bad_resp   = (r_state == S_DATA) && rvalid_i && (rresp_i != 2'b00);
    assign w_bad_target = w_npc_take && branch_en_i && (dnpc_i[1:0] != 2'b00);
    assign fault_o      = r_fault;
`else
    logic w_unused_rresp;
    assign w_unused_rresp = ^rresp_i;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_pc    <= RESET_PC;
            r_inst  <= C_NOP;
`ifdef IFU_FAULT_EN
            r_fault <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
`ifdef IFU_FAULT_EN
                    if (!r_fault) r_state <= S_ADDR;
`else
                    r_state <= S_ADDR;
`endif
                end
                S_ADDR: begin
                    if (arready_i) r_state <= S_DATA;
                end
                S_DATA: begin
                    if (rvalid_i) begin
`ifdef IFU_FAULT_EN
                        if (w_bad_resp) begin
                            r_fault <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_inst  <= rdata_i;
                            r_state <= S_HOLD;
                        end
`else
                        r_inst  <= rdata_i;
                        r_state <= S_HOLD;
`endif
                    end
                end
                S_HOLD: begin
                    if (ready_post_i) r_state <= npc_valid_i ? S_ADDR : S_WAIT_NPC;
                end
                S_WAIT_NPC: begin
                    if (npc_valid_i) r_state <= S_ADDR;
                end
                default: r_state <= S_IDLE;
            endcase

            // A misaligned redirect overrides the state chosen above and parks the FSM.
            if (w_npc_take) begin
`ifdef IFU_FAULT_EN
                if (w_bad_target) begin
                    r_fault <= 1'b1;
                    r_state <= S_IDLE;
                end else begin
                    r_pc <= w_npc;
                end
`else
                r_pc <= w_npc;
`endif
            end
        end
    end

    assign arvalid_o    = (r_state == S_ADDR);
    assign rready_o     = (r_state == S_DATA);
    assign valid_post_o = (r_state == S_HOLD);
    assign araddr_o     = r_pc;
    assign pc_o         = r_pc;
    assign inst_o       = r_inst;

endmodule
`default_nettype wire
